// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encodings.
package serial_subtractor_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] SHIFT_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    SHIFT = SHIFT_ENC,
    DONE  = DONE_ENC
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow are pure functions of the three inputs.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B, one bit per clock, LSB first.
// D is (N+1) bits wide; D[N] is the final borrow (1 when A < B).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// D is held stable there until out_ready is seen. The producer must hold A/B
// with in_valid until it observes in_ready.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   D,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  r_sr;
  logic [N-1:0]  r_next;
  logic          borrow;
  logic          borrow_nx;
  logic          diff_bit;
  logic [CW-1:0] cnt;
  logic [N:0]    d_q;
  logic          last;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (diff_bit),
    .bout (borrow_nx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and handshake/status outputs decoded from state.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result register after this cycle's shift: new bit enters at the MSB, so
  // after N shifts the first (LSB) difference bit sits at position 0.
  always_comb begin
    r_next        = r_sr >> 1;
    r_next[N-1]   = diff_bit;
    last          = (cnt == CNT_LAST);
  end

  // Operand/result shift registers, borrow, bit counter and the held output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= A;
            b_sr   <= B;
            r_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= r_next;
          borrow <= borrow_nx;
          cnt    <= cnt + CW'(1);
          if (last) d_q <= {borrow_nx, r_next};
        end
        default: ;
      endcase
    end
  end

  assign D = d_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at N=4, N=1 and N=8.
module tb_serial_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  logic       rst4_n, iv4, ir4, ov4, or4, busy4;
  logic [3:0] a4, b4;
  logic [4:0] d4;

  logic       rst_n, iv1, ir1, ov1, or1, busy1;
  logic [0:0] a1, b1;
  logic [1:0] d1;

  logic       iv8, ir8, ov8, or8, busy8;
  logic [7:0] a8, b8;
  logic [8:0] d8;

  serial_subtractor #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
    .out_valid(ov4), .out_ready(or4), .D(d4), .busy(busy4));

  serial_subtractor #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .out_valid(ov1), .out_ready(or1), .D(d1), .busy(busy1));

  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(or8), .D(d8), .busy(busy8));

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: exact A - B as an (n+1)-bit two's-complement value.
  function automatic logic [31:0] ref_diff(input int a, input int b, input int n);
    int v;
    v = a - b;
    return 32'(v) & ((32'd1 << (n + 1)) - 32'd1);
  endfunction

  // ---------------- N=4 driver ----------------
  // One full operation with optional output stall; when intrude is set a
  // different operand pair is offered during the stall and must be ignored.
  task automatic op4(input int a, input int b, input int stall, input bit intrude,
                     output logic [4:0] d);
    int lat;
    logic [31:0] want;
    @(negedge clk);
    iv4 = 1'b1; a4 = 4'(a); b4 = 4'(b); or4 = 1'b0;
    check("n4_in_ready_pre", {31'd0, ir4}, 32'd1);
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    exp_q.push_back(ref_diff(a, b, 4));
    for (lat = 0; lat < 40; lat++) begin
      @(negedge clk);
      if (ov4) break;
    end
    check("n4_latency", 32'(lat), 32'd4);
    d = d4;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check("n4_d", {27'd0, d4}, want);
    for (int i = 0; i < stall; i++) begin
      if (intrude) begin iv4 = 1'b1; a4 = 4'(i + 1); b4 = 4'd0; end
      @(negedge clk);
      check("n4_hold_valid", {31'd0, ov4}, 32'd1);
      check("n4_hold_d", {27'd0, d4}, ref_diff(a, b, 4));
      check("n4_hold_in_ready", {31'd0, ir4}, 32'd0);
      check("n4_hold_busy", {31'd0, busy4}, 32'd1);
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0; iv4 = 1'b0;
    @(negedge clk);
    check("n4_out_valid_after", {31'd0, ov4}, 32'd0);
    check("n4_in_ready_after", {31'd0, ir4}, 32'd1);
    check("n4_busy_after", {31'd0, busy4}, 32'd0);
  endtask

  task automatic seq4;
    logic [4:0] d;
    op4(9, 3, 0, 1'b0, d);   check("d_9_3", {27'd0, d}, 32'b00110);
    op4(3, 5, 1, 1'b0, d);   check("d_3_5", {27'd0, d}, 32'b11110);
    op4(0, 15, 0, 1'b0, d);  check("d_0_15", {27'd0, d}, 32'b10001);
    op4(15, 0, 2, 1'b0, d);  check("d_15_0", {27'd0, d}, 32'b01111);
    op4(7, 7, 0, 1'b0, d);   check("d_7_7", {27'd0, d}, 32'b00000);
    op4(12, 4, 6, 1'b1, d);  check("d_12_4_bp", {27'd0, d}, 32'b01000);

    // Asynchronous reset two cycles into SHIFT discards the partial result.
    @(negedge clk);
    iv4 = 1'b1; a4 = 4'd5; b4 = 4'd2;
    @(posedge clk); #1; iv4 = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst4_n = 1'b0; #1;
    check("rst_mid_in_ready", {31'd0, ir4}, 32'd1);
    check("rst_mid_out_valid", {31'd0, ov4}, 32'd0);
    check("rst_mid_busy", {31'd0, busy4}, 32'd0);
    check("rst_mid_d", {27'd0, d4}, 32'd0);
    @(negedge clk); rst4_n = 1'b1;
    op4(6, 1, 0, 1'b0, d);   check("d_6_1_after_rst", {27'd0, d}, 32'b00101);

    // Exhaustive pairs with random output stalls.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op4(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), d);
  endtask

  // ---------------- N=1 driver ----------------
  task automatic run1;
    int lat, a, b;
    for (int rep = 0; rep < 3; rep++)
      for (int p = 0; p < 4; p++) begin
        a = p >> 1; b = p & 1;
        @(negedge clk);
        iv1 = 1'b1; a1 = 1'(a); b1 = 1'(b); or1 = 1'b0;
        check("n1_in_ready_pre", {31'd0, ir1}, 32'd1);
        @(posedge clk); #1; iv1 = 1'b0;
        for (lat = 0; lat < 40; lat++) begin
          @(negedge clk);
          if (ov1) break;
        end
        check("n1_latency", 32'(lat), 32'd1);
        check("n1_d", {30'd0, d1}, ref_diff(a, b, 1));
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          check("n1_hold_d", {30'd0, d1}, ref_diff(a, b, 1));
        end
        or1 = 1'b1;
        @(posedge clk); #1; or1 = 1'b0;
      end
  endtask

  // ---------------- N=8 driver ----------------
  task automatic run8;
    int lat, a, b;
    for (int k = 0; k < 1000; k++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      @(negedge clk);
      iv8 = 1'b1; a8 = 8'(a); b8 = 8'(b); or8 = 1'b0;
      check("n8_in_ready_pre", {31'd0, ir8}, 32'd1);
      @(posedge clk); #1; iv8 = 1'b0;
      for (lat = 0; lat < 40; lat++) begin
        @(negedge clk);
        if (ov8) break;
      end
      check("n8_latency", 32'(lat), 32'd8);
      check("n8_d", {23'd0, d8}, ref_diff(a, b, 8));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("n8_hold_valid", {31'd0, ov8}, 32'd1);
      or8 = 1'b1;
      @(posedge clk); #1; or8 = 1'b0;
    end
  endtask

  // ---------------- main ----------------
  initial begin
    rst4_n = 1'b0; rst_n = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
    iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'd0, ir4}, 32'd1);
    check("reset_out_valid", {31'd0, ov4}, 32'd0);
    check("reset_busy", {31'd0, busy4}, 32'd0);
    check("reset_d", {27'd0, d4}, 32'd0);
    check("reset_d8", {23'd0, d8}, 32'd0);
    rst4_n = 1'b1; rst_n = 1'b1;
    fork
      seq4();
      run1();
      run8();
    join
    check("n4_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
